led_frame_scheduler: RTL

Sequences the 4x4 LED matrix datapath. It selects the frame to show, fetches that frame's 16-bit pixel word from frame storage with a req/ack handshake, and serialises it pixel-by-pixel on scan ticks to the display driver. Frame changes happen only at frame boundaries, so no image tearing occurs. The next frame is chosen by a debounced step pulse (manual mode) or by a frame-repeat counter (auto mode). The block sits between the debounce and divider blocks and the display driver.

---
 rtl/led_matrix_pkg.sv | 28 ++
 rtl/led_frame_scheduler_if.sv | 32 +++
 rtl/led_frame_shifter.sv | 107 ++++++++++
 rtl/led_frame_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared definitions for the LED matrix frame scheduler.
// Contents:
//   PIXELS_DEF / NUM_FRAMES_DEF : default geometry (4x4 matrix, 17 stored frames)
//   sched_state_e               : scheduler state encoding (S_FETCH, S_SCAN)
//   next_frame()                : frame index advance with wrap to 0
package led_matrix_pkg;

  localparam int unsigned PIXELS_DEF     = 32'd16;
  localparam int unsigned NUM_FRAMES_DEF = 32'd17;

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_SCAN  = 1'b1
  } sched_state_e;

  // Last frame wraps to frame 0, every other frame steps by one.
  function automatic int unsigned next_frame(input int unsigned cur,
                                             input int unsigned num_frames);
    int unsigned nxt;
    if (cur >= num_frames - 32'd1) begin
      nxt = 32'd0;
    end else begin
      nxt = cur + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/led_frame_scheduler_if.sv
// Frame storage fetch bus between the scheduler and the frame memory.
// Signals:
//   mem_req_out  : fetch request level (scheduler -> memory)
//   mem_addr_out : frame index being fetched, stable while req is high
//   mem_ack_in   : one-cycle acknowledge (memory -> scheduler)
//   mem_data_in  : frame word, valid with ack; bit PIXELS-1 is pixel 0
// Modports: master = scheduler side, slave = memory side.
interface led_frame_scheduler_if #(
  parameter int unsigned PIXELS  = 32'd16,
  parameter int unsigned FRAME_W = 32'd5
);

  logic               mem_req_out;
  logic [FRAME_W-1:0] mem_addr_out;
  logic               mem_ack_in;
  logic [PIXELS-1:0]  mem_data_in;

  modport master (
    output mem_req_out,
    output mem_addr_out,
    input  mem_ack_in,
    input  mem_data_in
  );

  modport slave (
    input  mem_req_out,
    input  mem_addr_out,
    output mem_ack_in,
    output mem_data_in
  );

endinterface

// File: rtl/led_frame_shifter.sv
// Frame buffer and pixel serialiser.
// Holds the fetched frame word, walks a pixel index on each accepted tick
// and presents one registered pixel per tick.
// Ports:
//   clk_i, rst_n_i   : clock, asynchronous active-low reset
//   load_i           : latch load_data_i into the buffer and restart at pixel 0
//   load_data_i      : frame word, bit PIXELS-1 is pixel 0
//   tick_i           : present the current pixel and advance the index
//   blank_i          : force the presented pixel off
//   pixel_idx_o      : index of the presented pixel
//   pixel_data_o     : LED state of the presented pixel
//   pixel_valid_o    : one-cycle strobe with each presented pixel
//   frame_done_o     : one-cycle strobe with the last pixel of the frame
//   last_o           : current index is the last pixel (combinational)
module led_frame_shifter
  import led_matrix_pkg::*;
#(
  parameter int unsigned PIXELS = PIXELS_DEF,
  localparam int unsigned IDX_W = $clog2(PIXELS)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic [PIXELS-1:0] load_data_i,
  input  logic              tick_i,
  input  logic              blank_i,
  output logic [IDX_W-1:0]  pixel_idx_o,
  output logic              pixel_data_o,
  output logic              pixel_valid_o,
  output logic              frame_done_o,
  output logic              last_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXELS - 32'd1);

  logic [PIXELS-1:0] buf_q,   buf_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [IDX_W-1:0]  pidx_q,  pidx_d;
  logic              pdata_q, pdata_d;
  logic              valid_q, valid_d;
  logic              done_q,  done_d;
  logic [IDX_W-1:0]  bit_sel_s;

  // Pixel 0 lives in the MSB, so the buffer is read from the top down.
  assign bit_sel_s = LAST_IDX - idx_q;
  assign last_o    = (idx_q == LAST_IDX);

  // Buffer load and pixel index walk.
  always_comb begin
    buf_d = buf_q;
    idx_d = idx_q;
    if (load_i) begin
      buf_d = load_data_i;
      idx_d = {IDX_W{1'b0}};
    end else if (tick_i) begin
      buf_d = buf_q;
      if (last_o) begin
        idx_d = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_q + IDX_W'(32'd1);
      end
    end else begin
      buf_d = buf_q;
      idx_d = idx_q;
    end
  end

  // Presented pixel; idx and data hold their last value between strobes.
  always_comb begin
    pidx_d  = pidx_q;
    pdata_d = pdata_q;
    valid_d = tick_i;
    done_d  = tick_i & last_o;
    if (tick_i) begin
      pidx_d  = idx_q;
      pdata_d = buf_q[bit_sel_s] & ~blank_i;
    end else begin
      pidx_d  = pidx_q;
      pdata_d = pdata_q;
    end
  end

  // Buffer, index and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_q   <= {PIXELS{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      pidx_q  <= {IDX_W{1'b0}};
      pdata_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      pidx_q  <= pidx_d;
      pdata_q <= pdata_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign pixel_idx_o   = pidx_q;
  assign pixel_data_o  = pdata_q;
  assign pixel_valid_o = valid_q;
  assign frame_done_o  = done_q;

endmodule

// File: rtl/led_frame_scheduler.sv
// LED matrix frame scheduler.
// Fetches the current frame word over a req/ack bus, serialises it one pixel
// per scan tick, and only switches frames at a scan boundary so the image
// never tears. Frame advance comes from a debounced step pulse (manual) or a
// repeat counter (auto). A fetch that is never acknowledged times out, sets a
// sticky error and rescans the previous buffer.
// Ports:
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   tick_in          : scan strobe, one pixel per tick (ignored while fetching)
//   step_in          : request next frame at the coming boundary
//   auto_in          : 1 = advance every AUTO_REPEAT scans, 0 = manual
//   blank_in         : force pixel data off, scanning continues
//   mem_if           : frame storage fetch bus (master side)
//   pixel_idx_out / pixel_data_out / pixel_valid_out : serial pixel stream
//   frame_out        : frame currently displayed
//   frame_done_out   : strobe with the last pixel of a scan
//   fetch_err_out    : sticky ack-timeout flag
module led_frame_scheduler
  import led_matrix_pkg::*;
#(
  parameter int unsigned PIXELS      = PIXELS_DEF,
  parameter int unsigned NUM_FRAMES  = NUM_FRAMES_DEF,
  parameter int unsigned AUTO_REPEAT = 32'd100,
  parameter int unsigned ACK_TIMEOUT = 32'd15,
  localparam int unsigned FRAME_W    = $clog2(NUM_FRAMES),
  localparam int unsigned IDX_W      = $clog2(PIXELS)
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         tick_in,
  input  logic                         step_in,
  input  logic                         auto_in,
  input  logic                         blank_in,
  led_frame_scheduler_if.master        mem_if,
  output logic [IDX_W-1:0]             pixel_idx_out,
  output logic                         pixel_data_out,
  output logic                         pixel_valid_out,
  output logic [FRAME_W-1:0]           frame_out,
  output logic                         frame_done_out,
  output logic                         fetch_err_out
);

  localparam int unsigned REP_W = $clog2(AUTO_REPEAT + 32'd1);
  localparam int unsigned TO_W  = $clog2(ACK_TIMEOUT + 32'd1);

  sched_state_e       state_q, state_d;
  logic               req_q,     req_d;
  logic [FRAME_W-1:0] frame_q,   frame_d;
  logic               pending_q, pending_d;
  logic [REP_W-1:0]   rep_q,     rep_d;
  logic [TO_W-1:0]    to_q,      to_d;
  logic               err_q,     err_d;

  logic fetch_active_s;
  logic ack_take_s;
  logic timeout_s;
  logic scan_tick_s;
  logic last_s;
  logic boundary_s;
  logic advance_s;

  // req lags the state by one edge after reset, so an ack is only honoured
  // once the request is actually visible on the bus.
  assign fetch_active_s = (state_q == S_FETCH) && req_q;
  assign ack_take_s     = fetch_active_s && mem_if.mem_ack_in;
  assign timeout_s      = fetch_active_s && !mem_if.mem_ack_in &&
                          (32'(to_q) == ACK_TIMEOUT - 32'd1);
  assign scan_tick_s    = (state_q == S_SCAN) && tick_in;
  assign boundary_s     = scan_tick_s && last_s;

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (ack_take_s || timeout_s) begin
          state_d = S_SCAN;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_SCAN: begin
        if (boundary_s) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_SCAN;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // FSM output: request level follows the upcoming state.
  always_comb begin
    req_d = 1'b0;
    case (state_d)
      S_FETCH: req_d = 1'b1;
      S_SCAN:  req_d = 1'b0;
      default: req_d = 1'b0;
    endcase
  end

  // Ack timeout counter and sticky error flag.
  always_comb begin
    to_d  = to_q;
    err_d = err_q;
    if (fetch_active_s) begin
      if (mem_if.mem_ack_in) begin
        to_d = {TO_W{1'b0}};
      end else if (timeout_s) begin
        to_d  = {TO_W{1'b0}};
        err_d = 1'b1;
      end else begin
        to_d = to_q + TO_W'(32'd1);
      end
    end else begin
      to_d = {TO_W{1'b0}};
    end
  end

  // Boundary frame selection; a step in the boundary cycle still counts.
  always_comb begin
    frame_d   = frame_q;
    rep_d     = rep_q;
    pending_d = pending_q | step_in;
    advance_s = 1'b0;
    if (boundary_s) begin
      pending_d = 1'b0;
      if (auto_in) begin
        if (pending_q || step_in) begin
          advance_s = 1'b1;
          rep_d     = {REP_W{1'b0}};
        end else if (32'(rep_q) + 32'd1 >= AUTO_REPEAT) begin
          advance_s = 1'b1;
          rep_d     = {REP_W{1'b0}};
        end else begin
          advance_s = 1'b0;
          rep_d     = rep_q + REP_W'(32'd1);
        end
      end else begin
        advance_s = pending_q | step_in;
        rep_d     = {REP_W{1'b0}};
      end
      if (advance_s) begin
        frame_d = FRAME_W'(next_frame(32'(frame_q), NUM_FRAMES));
      end else begin
        frame_d = frame_q;
      end
    end else if (!auto_in) begin
      rep_d = {REP_W{1'b0}};
    end else begin
      rep_d = rep_q;
    end
  end

  // Control registers outside the FSM state.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      req_q     <= 1'b0;
      frame_q   <= {FRAME_W{1'b0}};
      pending_q <= 1'b0;
      rep_q     <= {REP_W{1'b0}};
      to_q      <= {TO_W{1'b0}};
      err_q     <= 1'b0;
    end else begin
      req_q     <= req_d;
      frame_q   <= frame_d;
      pending_q <= pending_d;
      rep_q     <= rep_d;
      to_q      <= to_d;
      err_q     <= err_d;
    end
  end

  led_frame_shifter #(
    .PIXELS (PIXELS)
  ) u_shifter (
    .clk_i         (clk_in),
    .rst_n_i       (rst_n_in),
    .load_i        (ack_take_s),
    .load_data_i   (mem_if.mem_data_in),
    .tick_i        (scan_tick_s),
    .blank_i       (blank_in),
    .pixel_idx_o   (pixel_idx_out),
    .pixel_data_o  (pixel_data_out),
    .pixel_valid_o (pixel_valid_out),
    .frame_done_o  (frame_done_out),
    .last_o        (last_s)
  );

  assign mem_if.mem_req_out  = req_q;
  assign mem_if.mem_addr_out = frame_q;
  assign frame_out           = frame_q;
  assign fetch_err_out       = err_q;

endmodule
